// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
//   SPI mode-0 initiator for the on-chip SPI register peripheral. Takes one
//   16-bit write frame {wr, addr[6:0], data[7:0]} per valid/ready handshake and
//   shifts it out MSB first on nCS/SCLK/COPI. Write-only (no CIPO).
//   All pin timing is derived from i_clk. Every output is a flop.
//
// Parameters
//   CLK_DIV   clk cycles per SCLK half-period (>=3)
//   CS_SETUP  clk cycles from nCS low to start of first SCLK low phase (>=3)
//   CS_HOLD   clk cycles from last SCLK fall to nCS rise (>=3)
//   CS_GAP    clk cycles nCS stays high before the next command (>=4)
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_cmd_valid   command present
//   o_cmd_ready   controller can accept a command
//   i_cmd_wr      frame bit 15
//   i_cmd_addr    frame bits 14:8
//   i_cmd_data    frame bits 7:0
//   o_busy        high from acceptance until back in IDLE
//   o_done        one-cycle pulse in the cycle nCS rises
//   o_ncs         chip select, active low
//   o_sclk        serial clock, idles low
//   o_copi        serial data, changes only while SCLK is low
// -----------------------------------------------------------------------------
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_wr,
    input  logic [6:0] i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ncs,
    output logic       o_sclk,
    output logic       o_copi
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [4:0]    r_bit, w_bit_next;
    logic [15:0]   r_shift, w_shift_next;
    logic          r_ncs, w_ncs_next;
    logic          r_sclk, w_sclk_next;
    logic          r_ready, w_ready_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ncs   <= 1'b1;
            r_sclk  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_ncs   <= w_ncs_next;
            r_sclk  <= w_sclk_next;
            r_ready <= w_ready_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_ncs_next   = r_ncs;
        w_sclk_next  = r_sclk;
        w_ready_next = r_ready;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready_next = 1'b1;
                w_busy_next  = 1'b0;
                w_ncs_next   = 1'b1;
                w_sclk_next  = 1'b0;
                // Handshake uses the registered ready the source actually saw.
                if (i_cmd_valid && r_ready) begin
                    w_shift_next = {i_cmd_wr, i_cmd_addr, i_cmd_data};
                    w_ncs_next   = 1'b0;
                    w_busy_next  = 1'b1;
                    w_ready_next = 1'b0;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_SHIFT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_next  = '0;
                    w_sclk_next = ~r_sclk;
                    if (r_sclk) begin
                        // Falling edge: present the next bit, except after the
                        // 16th fall where bit 0 stays on COPI through HOLD.
                        w_bit_next = r_bit + 1'b1;
                        if (r_bit == 5'd15) begin
                            w_state_next = S_HOLD;
                        end else begin
                            w_shift_next = {r_shift[14:0], 1'b0};
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_next   = '0;
                    w_ncs_next   = 1'b1;
                    w_shift_next = '0;   // returns COPI to 0 with nCS
                    w_done_next  = 1'b1;
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b0;
                    w_ready_next = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // COPI is taken straight from the shift register MSB, which is itself a flop.
    assign o_copi      = r_shift[15];
    assign o_ncs       = r_ncs;
    assign o_sclk      = r_sclk;
    assign o_cmd_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
// Self-checking bench for spi_controller: three instances (CLK_DIV 4, 3, 7),
// per-instance expected-frame queues filled by the drivers and drained by
// pin-level monitors that decode frames and check timing from first principles.
module tb_spi_controller;

    localparam int NI       = 3;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_GAP   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic       valid [NI];
    logic       wr    [NI];
    logic [6:0] addr  [NI];
    logic [7:0] data  [NI];
    logic       ready [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic       ncs   [NI];
    logic       sclk  [NI];
    logic       copi  [NI];

    // Scoreboard: expected frame and its acceptance cycle, per instance.
    logic [15:0] exp_frame [NI][64];
    int          exp_t0    [NI][64];
    int          wp        [NI];
    int          rp        [NI];
    int          mon_rises [NI];
    // Behavioural model of the register peripheral on the far end of the bus.
    logic [7:0]  regs      [NI][128];

    task automatic chk(input int inst, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL inst%0d %s: actual=0x%0h required=0x%0h (cycle %0d)", inst, name, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int DIV = (gi == 0) ? 4 : ((gi == 1) ? 3 : 7);

        spi_controller #(
            .CLK_DIV (DIV),
            .CS_SETUP(CS_SETUP),
            .CS_HOLD (CS_HOLD),
            .CS_GAP  (CS_GAP)
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_cmd_valid(valid[gi]),
            .o_cmd_ready(ready[gi]),
            .i_cmd_wr   (wr[gi]),
            .i_cmd_addr (addr[gi]),
            .i_cmd_data (data[gi]),
            .o_busy     (busy[gi]),
            .o_done     (done[gi]),
            .o_ncs      (ncs[gi]),
            .o_sclk     (sclk[gi]),
            .o_copi     (copi[gi])
        );

        initial begin : mon
            int t0, rises, last_fall, last_rise, exp_ready, idx, done_cnt, frame_cnt;
            logic [15:0] bits;
            bit in_frame, terr, perr, have_prev, wait_ready, p_ncs, p_sclk, p_copi;
            t0 = 0; rises = 0; last_fall = 0; last_rise = 0; exp_ready = 0;
            idx = 0; done_cnt = 0; frame_cnt = 0; bits = '0;
            in_frame = 0; terr = 0; perr = 0; have_prev = 0; wait_ready = 0;
            p_ncs = 1; p_sclk = 0; p_copi = 0;
            for (int i = 0; i < 128; i++) regs[gi][i] = 8'h00;
            forever begin
                @(negedge clk);
                if (rst) begin
                    // A frame cut by reset is discarded, as the receiver would.
                    if (in_frame) rp[gi]++;
                    in_frame = 0; wait_ready = 0; have_prev = 0; perr = 0;
                    p_ncs = 1; p_sclk = 0; p_copi = 0; mon_rises[gi] = 0;
                end else begin
                    if (done[gi]) done_cnt++;
                    if (sclk[gi] && ncs[gi]) perr = 1;
                    if (sclk[gi] && (copi[gi] != p_copi)) perr = 1;
                    if (!ncs[gi] && p_ncs) begin
                        chk(gi, "frame_pending", (wp[gi] != rp[gi]) ? 1 : 0, 1);
                        idx = rp[gi] % 64;
                        t0 = exp_t0[gi][idx];
                        chk(gi, "ncs_fall_time", cyc, t0 + 1);
                        if (have_prev) chk(gi, "cs_gap_min", (cyc - last_rise >= CS_GAP) ? 1 : 0, 1);
                        in_frame = 1; rises = 0; bits = '0; terr = 0;
                    end
                    if (sclk[gi] && !p_sclk) begin
                        rises++;
                        mon_rises[gi] = rises;
                        bits = {bits[14:0], copi[gi]};
                        if (cyc != t0 + 1 + CS_SETUP + (2 * rises - 1) * DIV) terr = 1;
                    end
                    if (!sclk[gi] && p_sclk) last_fall = cyc;
                    if (ncs[gi] && !p_ncs && in_frame) begin
                        chk(gi, "frame_bits", int'(bits), int'(exp_frame[gi][idx]));
                        chk(gi, "rise_count", rises, 16);
                        chk(gi, "rise_timing_err", int'(terr), 0);
                        chk(gi, "last_fall_time", last_fall, t0 + 1 + CS_SETUP + 32 * DIV);
                        chk(gi, "ncs_rise_time", cyc, last_fall + CS_HOLD);
                        chk(gi, "done_pulse", int'(done[gi]), 1);
                        chk(gi, "protocol_err", int'(perr), 0);
                        if (rises == 16 && bits[15]) regs[gi][bits[14:8]] = bits[7:0];
                        rp[gi]++;
                        frame_cnt++;
                        in_frame = 0; perr = 0; mon_rises[gi] = 0;
                        exp_ready = t0 + 1 + CS_SETUP + 32 * DIV + CS_HOLD + CS_GAP;
                        wait_ready = 1; last_rise = cyc; have_prev = 1;
                    end
                    if (ready[gi] && wait_ready) begin
                        chk(gi, "ready_return_time", cyc, exp_ready);
                        chk(gi, "done_count", done_cnt, frame_cnt);
                        wait_ready = 0;
                    end
                    p_ncs = ncs[gi]; p_sclk = sclk[gi]; p_copi = copi[gi];
                end
            end
        end
    end

    // Called just after a negedge. Returns one negedge after acceptance with the
    // command fields scrambled, so any late sampling of cmd_* corrupts the frame.
    task automatic send(input int idx, input logic [15:0] f, input bit keep);
        int n;
        valid[idx] = 1'b1;
        wr[idx]    = f[15];
        addr[idx]  = f[14:8];
        data[idx]  = f[7:0];
        n = 0;
        while (!ready[idx] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(idx, "accept_wait_ok", int'(ready[idx]), 1);
        if (ready[idx]) begin
            exp_frame[idx][wp[idx] % 64] = f;
            exp_t0[idx][wp[idx] % 64]    = cyc;
            wp[idx]++;
            @(negedge clk);
        end
        if (!keep) valid[idx] = 1'b0;
        wr[idx]   = 1'($urandom);
        addr[idx] = 7'($urandom);
        data[idx] = 8'($urandom);
    endtask

    task automatic wait_idle(input int idx);
        int n;
        n = 0;
        while (!(ready[idx] && wp[idx] == rp[idx]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(idx, "idle_reached", (ready[idx] && wp[idx] == rp[idx]) ? 1 : 0, 1);
    endtask

    task automatic rand_run(input int idx);
        bit keep;
        for (int k = 0; k < 8; k++) begin
            keep = (k < 7) && ($urandom_range(0, 1) == 1);
            send(idx, 16'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_idle(idx);
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        int n;
        logic [7:0] s0, s1, s4;
        for (int i = 0; i < NI; i++) begin
            valid[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; data[i] = '0;
        end
        // Reset values on every instance.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk(i, "rst_ncs", int'(ncs[i]), 1);
            chk(i, "rst_sclk", int'(sclk[i]), 0);
            chk(i, "rst_copi", int'(copi[i]), 0);
            chk(i, "rst_ready", int'(ready[i]), 0);
            chk(i, "rst_busy", int'(busy[i]), 0);
            chk(i, "rst_done", int'(done[i]), 0);
        end
        rst = 1'b0;
        #1;
        chk(0, "ready_before_first_edge", int'(ready[0]), 0);
        @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk(i, "ready_after_release", int'(ready[i]), 1);

        // Reset asserted mid-cycle drops ready without waiting for a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk(0, "async_rst_ready", int'(ready[0]), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk(0, "ready_after_async_rst", int'(ready[0]), 1);

        // Single default frame, then back-to-back with valid held high.
        send(0, 16'h84A5, 1'b0);
        wait_idle(0);
        send(0, 16'h8011, 1'b1);
        send(0, 16'h8122, 1'b0);
        wait_idle(0);

        // Random traffic on all three divider settings concurrently.
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join

        // Reset at the 8th SCLK rise, then a clean frame.
        send(0, 16'h8C3C, 1'b0);
        n = 0;
        while (mon_rises[0] < 8 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(0, "reached_rise8", (mon_rises[0] >= 8) ? 1 : 0, 1);
        #1;
        rst = 1'b1;
        #1;
        chk(0, "midframe_rst_ncs", int'(ncs[0]), 1);
        chk(0, "midframe_rst_sclk", int'(sclk[0]), 0);
        chk(0, "midframe_rst_copi", int'(copi[0]), 0);
        chk(0, "midframe_rst_ready", int'(ready[0]), 0);
        chk(0, "midframe_rst_busy", int'(busy[0]), 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        send(0, 16'h8233, 1'b0);
        wait_idle(0);

        // Loopback into the register peripheral model.
        send(0, {1'b1, 7'h00, 8'hF0}, 1'b0);
        send(0, {1'b1, 7'h04, 8'h80}, 1'b0);
        wait_idle(0);
        chk(0, "periph_out_enable", int'(regs[0][0]), 32'hF0);
        chk(0, "periph_duty", int'(regs[0][4]), 32'h80);
        s0 = regs[0][0]; s1 = regs[0][1]; s4 = regs[0][4];
        send(0, {1'b0, 7'h01, 8'h5A}, 1'b0);
        wait_idle(0);
        chk(0, "read_frame_reg0", int'(regs[0][0]), int'(s0));
        chk(0, "read_frame_reg1", int'(regs[0][1]), int'(s1));
        chk(0, "read_frame_reg4", int'(regs[0][4]), int'(s4));

        for (int i = 0; i < NI; i++) chk(i, "queue_drained", wp[i] - rp[i], 0);
        summary();
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        summary();
        $finish;
    end

endmodule
